// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the programmable sequence detector.
// Holds the detector state enum, its width, the length clamp and the
// length-to-bitmask builder used by the compare logic.
package seq_det_pkg;

   localparam int STATE_W   = 2;
   localparam int LEN_LIMIT = 64;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ARMED = 2'd2
   } state_t;

   // Clamp a requested pattern length to the largest length the instance supports.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

   // Build a mask with the low 'len' bits set; bits at or above len stay 0.
   function automatic logic [LEN_LIMIT-1:0] build_lenmask(input int unsigned len);
      logic [LEN_LIMIT-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < LEN_LIMIT; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: W-bit saturating up-counter.
// clr wins over inc; the count holds at all-ones once reached.
module seq_det_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count events, stop at full scale, clear on request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector.
// Pattern, length and overlap mode are loaded with cfg_load; the first bit
// received lines up with pattern bit len-1. A registered one-cycle match
// pulse fires for each hit and a saturating counter tallies hits.
// Optional build macro SEQ_DET_PROG_MASK_EN adds cfg_mask, where a 1 marks
// the corresponding pattern bit as don't-care.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
`ifdef SEQ_DET_PROG_MASK_EN
   input  logic [MAX_LEN-1:0] cfg_mask,
`endif
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy
);

   state_t               state, state_nxt;
   logic [MAX_LEN-1:0]   hist, hist_nxt, post_shift;
   logic [LEN_W-1:0]     fill, fill_nxt, fill_inc;
   logic [LEN_W-1:0]     len_q, len_load;
   logic [MAX_LEN-1:0]   pat_q;
   logic [MAX_LEN-1:0]   mask_q;
   logic                 ovl_q;
   logic [LEN_LIMIT-1:0] len_mask;
   logic                 cmp_ok;
   logic                 hit;

   assign len_load = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
   assign len_mask = build_lenmask(32'(len_q));
   assign fill_inc = fill + 1'b1;

   // History as it looks after this cycle's sample is taken; unchanged when no sample.
   assign post_shift = in_valid ? {hist[MAX_LEN-2:0], in} : hist;

   // Masked exact compare over the active length; bits above len never count.
   assign cmp_ok = ((LEN_LIMIT'(post_shift ^ pat_q) & ~LEN_LIMIT'(mask_q) & len_mask) == '0);

   assign busy = (state != IDLE);

   // Next-state, history, fill and hit decode; cfg_load overrides everything and drops the sample.
   always_comb begin
      state_nxt = state;
      hist_nxt  = post_shift;
      fill_nxt  = fill;
      hit       = 1'b0;
      if (cfg_load) begin
         hist_nxt  = '0;
         fill_nxt  = '0;
         state_nxt = (len_load == '0) ? IDLE : FILL;
      end else begin
         case (state)
            IDLE: begin
               fill_nxt = '0;
            end
            FILL: begin
               if (len_q == '0) begin
                  state_nxt = IDLE;
               end else if (in_valid) begin
                  fill_nxt = fill_inc;
                  if (fill_inc == len_q) begin
                     state_nxt = ARMED;
                     hit       = cmp_ok;
                  end
               end
            end
            ARMED: begin
               if (in_valid) begin
                  hit = cmp_ok;
               end
            end
            default: begin
               state_nxt = IDLE;
               fill_nxt  = '0;
            end
         endcase
         if (hit && !ovl_q) begin
            fill_nxt  = '0;
            state_nxt = FILL;
         end
      end
   end

   // State, history, fill count and registered match pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         hist  <= '0;
         fill  <= '0;
         match <= 1'b0;
      end else begin
         state <= state_nxt;
         hist  <= hist_nxt;
         fill  <= fill_nxt;
         match <= hit;
      end
   end

   // Configuration latched on the load strobe with the length already clamped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= '0;
         pat_q <= '0;
         ovl_q <= 1'b0;
      end else if (cfg_load) begin
         len_q <= len_load;
         pat_q <= cfg_pattern;
         ovl_q <= cfg_overlap;
      end
   end

`ifdef SEQ_DET_PROG_MASK_EN
   // Don't-care mask latched alongside the rest of the configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
      end else if (cfg_load) begin
         mask_q <= cfg_mask;
      end
   end
`else
   assign mask_q = '0;
`endif

   seq_det_sat_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit),
      .clr (cnt_clr),
      .cnt (match_cnt)
   );

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: self-checking bench for seq_det_prog (MAX_LEN=8, CNT_W=2).
// A bit-queue reference model predicts match, match_cnt and busy every cycle;
// directed sequences add literal expectations. Define SEQ_DET_PROG_MASK_EN
// to also cover the don't-care mask.
module tb_seq_det_prog;

   localparam int ML = 8;
   localparam int CW = 2;
   localparam int LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in, cfg_load, cfg_overlap, cnt_clr;
   logic [ML-1:0] cfg_pattern;
   logic [LW-1:0] cfg_len;
   logic [ML-1:0] cfg_mask;
   logic          match, busy;
   logic [CW-1:0] match_cnt;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Reference model state
   bit            q[$];
   int            m_len;
   logic [ML-1:0] m_pat, m_mask;
   bit            m_ovl;
   logic          exp_match;
   int            exp_cnt;

   seq_det_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in          (in),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_PROG_MASK_EN
      .cfg_mask    (cfg_mask),
`endif
      .cnt_clr     (cnt_clr),
      .match       (match),
      .match_cnt   (match_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: keep the accepted bits since the last restart and
   // test the newest len of them against the pattern after every sample.
   always @(posedge clk or posedge rst) begin
      bit hit;
      if (rst) begin
         q.delete();
         m_len = 0; m_pat = '0; m_mask = '0; m_ovl = 1'b0;
         exp_match = 1'b0; exp_cnt = 0;
      end else begin
         hit = 1'b0;
         if (cfg_load) begin
            m_len = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
            m_pat = cfg_pattern;
            m_ovl = cfg_overlap;
`ifdef SEQ_DET_PROG_MASK_EN
            m_mask = cfg_mask;
`else
            m_mask = '0;
`endif
            q.delete();
         end else if (in_valid && m_len != 0) begin
            q.push_back(in);
            if (q.size() > 64) void'(q.pop_front());
            if (q.size() >= m_len) begin
               hit = 1'b1;
               for (int i = 0; i < m_len; i++) begin
                  if (!m_mask[m_len-1-i] && (q[q.size()-m_len+i] != m_pat[m_len-1-i])) hit = 1'b0;
               end
            end
            if (hit && !m_ovl) q.delete();
         end
         exp_match = hit;
         if (cnt_clr) exp_cnt = 0;
         else if (hit && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, away from the active edge, hold the DUT against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("cyc_match", 32'(match), 32'(exp_match));
         checkOutput("cyc_cnt", 32'(match_cnt), 32'(exp_cnt));
         checkOutput("cyc_busy", 32'(busy), 32'(m_len != 0));
      end
   end

   task automatic applyStimulus(input logic v, input logic b);
      in_valid = v;
      in       = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   task automatic loadCfg(input logic [ML-1:0] pat, input logic [LW-1:0] len, input logic ovl,
                          input logic [ML-1:0] msk, input logic v, input logic b);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_mask    = msk;
      cfg_load    = 1'b1;
      cnt_clr     = 1'b1;
      in_valid    = v;
      in          = b;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
      in_valid = 1'b0;
   endtask

   // Feed a bit list and check the literal match expectation after each bit.
   task automatic feedBits(input string name, input bit bits[], input bit expm[]);
      for (int i = 0; i < bits.size(); i++) begin
         applyStimulus(1'b1, bits[i]);
         checkOutput(name, 32'(match), 32'(expm[i]));
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_mask = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_match", 32'(match), 32'd0);
      checkOutput("rst_cnt", 32'(match_cnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      cmp_en = 1'b1;

      $display("[TB] overlap 1011");
      loadCfg(8'b0000_1011, 4'd4, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("ovl_busy", 32'(busy), 32'd1);
      feedBits("ovl_match", '{1,0,1,1,0,1,1}, '{0,0,0,1,0,0,1});
      checkOutput("ovl_cnt", 32'(match_cnt), 32'd2);

      $display("[TB] non-overlap 1011");
      loadCfg(8'b0000_1011, 4'd4, 1'b0, '0, 1'b0, 1'b0);
      feedBits("novl_match", '{1,0,1,1,0,1,1}, '{0,0,0,1,0,0,0});
      checkOutput("novl_cnt", 32'(match_cnt), 32'd1);

      $display("[TB] gapped valid 110");
      loadCfg(8'b0000_0110, 4'd3, 1'b1, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1); checkOutput("gap_m1", 32'(match), 32'd0);
      applyStimulus(1'b0, 1'b0); checkOutput("gap_m2", 32'(match), 32'd0);
      applyStimulus(1'b1, 1'b1); checkOutput("gap_m3", 32'(match), 32'd0);
      applyStimulus(1'b0, 1'b1); checkOutput("gap_m4", 32'(match), 32'd0);
      applyStimulus(1'b1, 1'b0); checkOutput("gap_m5", 32'(match), 32'd1);
      applyStimulus(1'b0, 1'b0); checkOutput("gap_idle", 32'(match), 32'd0);

      $display("[TB] length clamp 12 -> 8");
      loadCfg(8'b1010_0101, 4'd12, 1'b1, '0, 1'b0, 1'b0);
      feedBits("clamp_match", '{1,0,1,0,0,1,0,1}, '{0,0,0,0,0,0,0,1});

      $display("[TB] cfg_load drops concurrent sample");
      loadCfg(8'b0000_1011, 4'd4, 1'b1, '0, 1'b0, 1'b0);
      feedBits("pre_match", '{1,0}, '{0,0});
      loadCfg(8'b0000_1011, 4'd4, 1'b1, '0, 1'b1, 1'b1);
      feedBits("drop_match", '{0,1,1,0,1,1}, '{0,0,0,0,0,1});

      $display("[TB] len 0 disables");
      loadCfg(8'b0000_0001, 4'd0, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("len0_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checkOutput("len0_match", 32'(match), 32'd0);
      end

      $display("[TB] saturating counter");
      loadCfg(8'b0000_0001, 4'd1, 1'b1, '0, 1'b0, 1'b0);
      feedBits("sat_match", '{1,1,1,1,1}, '{1,1,1,1,1});
      checkOutput("sat_cnt", 32'(match_cnt), 32'd3);
      applyStimulus(1'b1, 1'b0);
      checkOutput("len1_miss", 32'(match), 32'd0);
      cnt_clr = 1'b1;
      applyStimulus(1'b1, 1'b1);
      checkOutput("clr_hit_match", 32'(match), 32'd1);
      checkOutput("clr_hit_cnt", 32'(match_cnt), 32'd0);

      $display("[TB] reset while armed");
      loadCfg(8'b0000_1011, 4'd4, 1'b1, '0, 1'b0, 1'b0);
      feedBits("arm_match", '{1,0,1,1}, '{0,0,0,1});
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_match", 32'(match), 32'd0);
      checkOutput("mid_rst_cnt", 32'(match_cnt), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);

`ifdef SEQ_DET_PROG_MASK_EN
      $display("[TB] don't-care mask");
      loadCfg(8'b0000_1001, 4'd4, 1'b0, 8'b0000_0110, 1'b0, 1'b0);
      feedBits("mask_1001", '{1,0,0,1}, '{0,0,0,1});
      feedBits("mask_1111", '{1,1,1,1}, '{0,0,0,1});
      feedBits("mask_0111", '{0,1,1,1}, '{0,0,0,0});
`endif

      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
